branch_stall_ctrl: RTL and testbench

//  ID-stage hazard sequencer for the 5-stage RV32I pipeline with branches resolved in ID.

---
 rtl/branch_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_stall_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_stall_ctrl.sv
// ID-stage hazard sequencer: load-use / ALU->branch / load->branch stalls,
// branch-comparator forwarding selects, and a saturating stall-cycle counter.
module branch_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             branch,
  input  logic [4:0]       IF_IDrs1,
  input  logic [4:0]       IF_IDrs2,
  input  logic [4:0]       ID_EXrd,
  input  logic             ID_EXregWrite,
  input  logic             ID_EXmemRead,
  input  logic [4:0]       EX_MEMrd,
  input  logic             EX_MEMregWrite,
  input  logic             EX_MEMmemRead,
  input  logic [4:0]       MEM_WBrd,
  input  logic             MEM_WBregWrite,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             bubble,
  output logic [1:0]       rs1_MUX,
  output logic [1:0]       rs2_MUX,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {S_IDLE, S_HOLD2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mId1, mId2, mEm1, mEm2, mWb1, mWb2;
  logic [1:0] need1, need2, needMax, fwd1, fwd2;
  logic stall;

  function automatic logic regMatch(input logic we, input logic [4:0] rd,
                                    input logic [4:0] r);
    return we && (rd != 5'd0) && (rd == r);
  endfunction

  // A producer in ID/EX shadows EX/MEM for the same source, so EX/MEM loads
  // only cost a stall when ID/EX does not also match.
  function automatic logic [1:0] stallNeed(input logic br, input logic mId,
                                           input logic idLoad, input logic mEm,
                                           input logic emLoad);
    logic [1:0] n;
    n = 2'd0;
    if (!br && mId && idLoad)        n = 2'd1;
    else if (br && mId && !idLoad)   n = 2'd1;
    else if (br && mId && idLoad)    n = 2'd2;
    else if (br && mEm && emLoad)    n = 2'd1;
    return n;
  endfunction

  function automatic logic [1:0] fwdSel(input logic mEm, input logic emLoad,
                                        input logic mWb);
    logic [1:0] s;
    s = 2'b00;
    if (mEm && !emLoad) s = 2'b01;
    else if (mWb)       s = 2'b10;
    return s;
  endfunction

  assign mId1 = regMatch(ID_EXregWrite, ID_EXrd, IF_IDrs1);
  assign mId2 = regMatch(ID_EXregWrite, ID_EXrd, IF_IDrs2);
  assign mEm1 = regMatch(EX_MEMregWrite, EX_MEMrd, IF_IDrs1);
  assign mEm2 = regMatch(EX_MEMregWrite, EX_MEMrd, IF_IDrs2);
  assign mWb1 = regMatch(MEM_WBregWrite, MEM_WBrd, IF_IDrs1);
  assign mWb2 = regMatch(MEM_WBregWrite, MEM_WBrd, IF_IDrs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst_n so they show reset values while reset is held.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    need1      = stallNeed(branch, mId1, ID_EXmemRead, mEm1, EX_MEMmemRead);
    need2      = stallNeed(branch, mId2, ID_EXmemRead, mEm2, EX_MEMmemRead);
    needMax    = (need1 > need2) ? need1 : need2;
    fwd1       = fwdSel(mEm1, EX_MEMmemRead, mWb1);
    fwd2       = fwdSel(mEm2, EX_MEMmemRead, mWb2);
    PCwrite    = 1'b1;
    IF_IDwrite = 1'b1;
    bubble     = 1'b0;
    rs1_MUX    = 2'b00;
    rs2_MUX    = 2'b00;
    busy       = 1'b0;

    if (!rst_n || flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_HOLD2) begin
      stall   = 1'b1;
      state_d = S_IDLE;
    end else begin
      stall = (needMax != 2'd0);
      if (needMax == 2'd2) state_d = S_HOLD2;
    end

    if (stall && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    PCwrite    = !stall;
    IF_IDwrite = !stall;
    bubble     = stall;
    busy       = rst_n && (state_q == S_HOLD2);
    if (rst_n && branch && !stall) begin
      rs1_MUX = fwd1;
      rs2_MUX = fwd2;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed bench for branch_stall_ctrl: expected output vectors are queued as
// each step is driven and popped for comparison mid-cycle.
module tb_branch_stall_ctrl;

  localparam int CNT_W = 3;
  localparam int EW    = 8 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             branch;
  logic [4:0]       IF_IDrs1, IF_IDrs2, ID_EXrd, EX_MEMrd, MEM_WBrd;
  logic             ID_EXregWrite, ID_EXmemRead;
  logic             EX_MEMregWrite, EX_MEMmemRead, MEM_WBregWrite;
  logic             PCwrite, IF_IDwrite, bubble, busy;
  logic [1:0]       rs1_MUX, rs2_MUX;
  logic [CNT_W-1:0] stall_cnt;

  logic [EW-1:0] expQ[$];
  int checks = 0;
  int errors = 0;

  branch_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .branch(branch),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2),
    .ID_EXrd(ID_EXrd), .ID_EXregWrite(ID_EXregWrite), .ID_EXmemRead(ID_EXmemRead),
    .EX_MEMrd(EX_MEMrd), .EX_MEMregWrite(EX_MEMregWrite), .EX_MEMmemRead(EX_MEMmemRead),
    .MEM_WBrd(MEM_WBrd), .MEM_WBregWrite(MEM_WBregWrite),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .bubble(bubble),
    .rs1_MUX(rs1_MUX), .rs2_MUX(rs2_MUX), .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector {PCwrite, IF_IDwrite, bubble, rs1_MUX, rs2_MUX, busy, stall_cnt}.
  function automatic logic [EW-1:0] expv(input logic stall, input logic [1:0] m1,
                                         input logic [1:0] m2, input logic bsy,
                                         input int cnt);
    logic [CNT_W-1:0] c;
    c = cnt[CNT_W-1:0];
    return {!stall, !stall, stall, m1, m2, bsy, c};
  endfunction

  task automatic clearInputs();
    flush = 0; branch = 0; IF_IDrs1 = 0; IF_IDrs2 = 0;
    ID_EXrd = 0; ID_EXregWrite = 0; ID_EXmemRead = 0;
    EX_MEMrd = 0; EX_MEMregWrite = 0; EX_MEMmemRead = 0;
    MEM_WBrd = 0; MEM_WBregWrite = 0;
  endtask

  task automatic beginStep();
    @(negedge clk);
    clearInputs();
  endtask

  task automatic applyStimulus(input logic [EW-1:0] e);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    logic [EW-1:0] obs, e;
    #2;
    obs = {PCwrite, IF_IDwrite, bubble, rs1_MUX, rs2_MUX, busy, stall_cnt};
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic setLoadBranch();
    branch = 1; IF_IDrs1 = 5'd1; IF_IDrs2 = 5'd8;
    ID_EXrd = 5'd8; ID_EXregWrite = 1; ID_EXmemRead = 1;
  endtask

  task automatic setLoadUse();
    IF_IDrs1 = 5'd5; ID_EXrd = 5'd5; ID_EXregWrite = 1; ID_EXmemRead = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 0));
    checkOutput("reset");
    @(negedge clk); rst_n = 1'b1;

    beginStep(); applyStimulus(expv(0, 2'b00, 2'b00, 0, 0)); checkOutput("idle");

    beginStep(); setLoadUse();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 0)); checkOutput("loadUseStall");
    beginStep(); IF_IDrs1 = 5'd5; EX_MEMrd = 5'd5; EX_MEMregWrite = 1; EX_MEMmemRead = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 1)); checkOutput("loadUseResume");

    beginStep(); branch = 1; IF_IDrs1 = 5'd6; IF_IDrs2 = 5'd7;
    ID_EXrd = 5'd6; ID_EXregWrite = 1;
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 1)); checkOutput("aluBranchStall");
    beginStep(); branch = 1; IF_IDrs1 = 5'd6; IF_IDrs2 = 5'd7;
    EX_MEMrd = 5'd6; EX_MEMregWrite = 1;
    applyStimulus(expv(0, 2'b01, 2'b00, 0, 2)); checkOutput("aluBranchFwd");

    beginStep(); setLoadBranch();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 2)); checkOutput("loadBranchStall1");
    beginStep(); branch = 1; IF_IDrs1 = 5'd1; IF_IDrs2 = 5'd8;
    EX_MEMrd = 5'd8; EX_MEMregWrite = 1; EX_MEMmemRead = 1;
    applyStimulus(expv(1, 2'b00, 2'b00, 1, 3)); checkOutput("loadBranchHold2");
    beginStep(); branch = 1; IF_IDrs1 = 5'd1; IF_IDrs2 = 5'd8;
    MEM_WBrd = 5'd8; MEM_WBregWrite = 1;
    applyStimulus(expv(0, 2'b00, 2'b10, 0, 4)); checkOutput("loadBranchFwd");

    beginStep(); ID_EXrd = 5'd0; ID_EXregWrite = 1; ID_EXmemRead = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 4)); checkOutput("x0LoadNoStall");
    beginStep(); branch = 1; ID_EXregWrite = 1; ID_EXmemRead = 1;
    EX_MEMregWrite = 1; MEM_WBregWrite = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 4)); checkOutput("x0BranchNoFwd");

    beginStep(); branch = 1; IF_IDrs1 = 5'd9; IF_IDrs2 = 5'd9;
    EX_MEMrd = 5'd9; EX_MEMregWrite = 1; MEM_WBrd = 5'd9; MEM_WBregWrite = 1;
    applyStimulus(expv(0, 2'b01, 2'b01, 0, 4)); checkOutput("exMemPriority");

    beginStep(); branch = 1; IF_IDrs1 = 5'd3;
    EX_MEMrd = 5'd3; EX_MEMregWrite = 1; EX_MEMmemRead = 1;
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 4)); checkOutput("exMemLoadStall");
    beginStep(); branch = 1; IF_IDrs1 = 5'd3; MEM_WBrd = 5'd3; MEM_WBregWrite = 1;
    applyStimulus(expv(0, 2'b10, 2'b00, 0, 5)); checkOutput("exMemLoadFwd");

    beginStep(); IF_IDrs1 = 5'd4; EX_MEMrd = 5'd4; EX_MEMregWrite = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 5)); checkOutput("noBranchNoFwd");

    beginStep(); setLoadBranch();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 5)); checkOutput("flushSeqStall1");
    beginStep(); flush = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 1, 6)); checkOutput("flushInHold2");
    beginStep();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 6)); checkOutput("afterFlush");

    beginStep(); setLoadUse(); flush = 1;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 6)); checkOutput("flushOverDetect");
    beginStep();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 6)); checkOutput("flushNoCount");

    beginStep(); setLoadUse();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 6)); checkOutput("satStall1");
    beginStep();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 7)); checkOutput("satReachMax");
    beginStep(); setLoadUse();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 7)); checkOutput("satStall2");
    beginStep();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 7)); checkOutput("satHold");

    beginStep(); setLoadBranch();
    applyStimulus(expv(1, 2'b00, 2'b00, 0, 7)); checkOutput("resetSeqStall1");
    beginStep();
    applyStimulus(expv(1, 2'b00, 2'b00, 1, 7)); checkOutput("resetSeqHold2");
    #1 rst_n = 1'b0;
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 0)); checkOutput("resetMidHold2");
    @(negedge clk); rst_n = 1'b1;
    beginStep();
    applyStimulus(expv(0, 2'b00, 2'b00, 0, 0)); checkOutput("afterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
